// File: rtl/b1_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : b1_input_sequencer
// Description : Upstream feeder for the B1 convolution systolic array.
//               Buffers a valid/ready sample stream in a FIFO, drives x_in
//               gap-free once a frame is available, appends a zero-flush tail
//               after every frame, and reports frame completion, the frame
//               sample count and a sticky mid-frame underrun error.
// Revision    : 1.0 - initial release
// ============================================================================
module b1_input_sequencer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int FLUSH_LEN  = 7,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] x_in,
    output logic [DATA_W-1:0] y_in,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic              underrun_err
);

    // Pointer width relies on FIFO_DEPTH being a power of two so that the
    // pointers wrap naturally; occupancy needs one extra bit to express "full".
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_FL_W  = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // FIFO storage: {last, data}
    logic [DATA_W:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_OCC_W-1:0]   r_fifo_cnt;
    logic [c_OCC_W-1:0]   r_frames_q;

    logic [DATA_W:0]      w_head;
    logic [DATA_W-1:0]    w_head_data;
    logic                 w_head_last;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_start;

    // Sequencer state and registered outputs
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_FL_W-1:0]    r_flush_cnt;
    logic [c_FL_W-1:0]    w_flush_cnt_nxt;
    logic [CNT_W-1:0]     r_frame_cnt;
    logic [CNT_W-1:0]     w_frame_cnt_nxt;
    logic [DATA_W-1:0]    r_x_in;
    logic [DATA_W-1:0]    w_x_in_nxt;
    logic                 r_x_valid;
    logic                 w_x_valid_nxt;
    logic                 r_frame_done;
    logic                 w_frame_done_nxt;
    logic [CNT_W-1:0]     r_sample_cnt;
    logic [CNT_W-1:0]     w_sample_cnt_nxt;
    logic                 r_underrun;
    logic                 w_underrun_nxt;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_data = w_head[DATA_W-1:0];
    assign w_head_last = w_head[DATA_W];
    assign w_full      = (r_fifo_cnt == c_OCC_W'(FIFO_DEPTH));
    assign w_empty     = (r_fifo_cnt == '0);
    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign w_push      = s_valid && !w_full;
    // A frame may start once a complete frame is queued, or when the FIFO can
    // take no more input and waiting for a last marker would deadlock.
    assign w_start     = (r_frames_q != '0) || w_full;

    // Sample storage write port; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    // FIFO pointers, occupancy and count of complete frames held in the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_frames_q <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_OCC_W'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_OCC_W'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_push && s_last, w_pop && w_head_last})
                2'b10:   r_frames_q <= r_frames_q + c_OCC_W'(1);
                2'b01:   r_frames_q <= r_frames_q - c_OCC_W'(1);
                default: r_frames_q <= r_frames_q;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, FIFO pop and next registered output values
    always_comb begin
        w_state_nxt      = r_state;
        w_pop            = 1'b0;
        w_x_in_nxt       = '0;
        w_x_valid_nxt    = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_sample_cnt_nxt = r_sample_cnt;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_flush_cnt_nxt  = r_flush_cnt;
        w_underrun_nxt   = r_underrun;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_pop           = 1'b1;
                    w_x_in_nxt      = w_head_data;
                    w_x_valid_nxt   = 1'b1;
                    w_frame_cnt_nxt = CNT_W'(1);
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = w_head_last ? ST_FLUSH : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_x_in_nxt    = w_head_data;
                    w_x_valid_nxt = 1'b1;
                    if (r_frame_cnt != '1) begin
                        w_frame_cnt_nxt = r_frame_cnt + CNT_W'(1);
                    end
                    if (w_head_last) begin
                        w_flush_cnt_nxt = '0;
                        w_state_nxt     = ST_FLUSH;
                    end
                end else begin
                    // The array cannot stall: emit a bubble, flag it, keep going.
                    w_underrun_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                // FLUSH_LEN zero cycles follow the last sample; the completion
                // pulse lands on the first IDLE cycle afterwards.
                if (r_flush_cnt == c_FL_W'(FLUSH_LEN)) begin
                    w_frame_done_nxt = 1'b1;
                    w_sample_cnt_nxt = r_frame_cnt;
                    w_state_nxt      = ST_IDLE;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt + c_FL_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered array-side outputs and frame bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt  <= '0;
            r_frame_cnt  <= '0;
            r_x_in       <= '0;
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sample_cnt <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_flush_cnt  <= w_flush_cnt_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_x_in       <= w_x_in_nxt;
            r_x_valid    <= w_x_valid_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_sample_cnt <= w_sample_cnt_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    assign s_ready      = !w_full;
    assign x_in         = r_x_in;
    assign y_in         = '0;
    assign x_valid      = r_x_valid;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;
    assign sample_cnt   = r_sample_cnt;
    assign underrun_err = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_b1_input_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_b1_input_sequencer
// Description : Self-checking bench for b1_input_sequencer. A queue-based
//               behavioural model predicts every output each cycle; directed
//               scenarios add fixed expectations for order, timing and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b1_input_sequencer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int FL    = 7;
    localparam int CW    = 16;
    localparam int OW    = 3 + 2 * DW + 1 + CW + 1;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic [DW-1:0] s_data  = '0;
    logic          s_valid = 1'b0;
    logic          s_last  = 1'b0;
    logic          s_ready;
    logic [DW-1:0] x_in;
    logic [DW-1:0] y_in;
    logic          x_valid;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] sample_cnt;
    logic          underrun_err;

    b1_input_sequencer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .FLUSH_LEN  (FL),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .x_in         (x_in),
        .y_in         (y_in),
        .x_valid      (x_valid),
        .busy         (busy),
        .frame_done   (frame_done),
        .sample_cnt   (sample_cnt),
        .underrun_err (underrun_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          mq[$];
    ent_t          m_e;
    bit            m_full;
    int            m_frames;
    bit            m_stream;
    int            m_flush_left;
    int            m_cnt;
    int            m_scnt;
    logic [DW-1:0] m_x;
    bit            m_v;
    bit            m_done;
    bit            m_err;
    logic [OW-1:0] m_exp;

    task automatic model_step();
        if (rst) begin
            mq.delete();
            m_stream = 0; m_flush_left = 0; m_cnt = 0; m_scnt = 0;
            m_x = '0; m_v = 0; m_done = 0; m_err = 0;
        end else begin
            m_full   = (mq.size() == DEPTH);
            m_frames = 0;
            foreach (mq[i]) if (mq[i].last) m_frames++;
            m_done = 0;
            m_x    = '0;
            m_v    = 0;
            if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    m_done = 1;
                    m_scnt = m_cnt;
                end
            end else if (m_stream) begin
                if (mq.size() > 0) begin
                    m_e = mq.pop_front();
                    m_x = m_e.data; m_v = 1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                    if (m_e.last) begin
                        m_stream = 0;
                        m_flush_left = FL + 1;
                    end
                end else begin
                    m_err = 1;
                end
            end else if (m_frames > 0 || m_full) begin
                m_e = mq.pop_front();
                m_x = m_e.data; m_v = 1; m_cnt = 1;
                if (m_e.last) m_flush_left = FL + 1;
                else          m_stream = 1;
            end
            if (s_valid && !m_full) begin
                m_e.last = s_last;
                m_e.data = s_data;
                mq.push_back(m_e);
            end
        end
        m_exp = {(m_stream || m_flush_left > 0), (mq.size() < DEPTH), m_v, m_x,
                 {DW{1'b0}}, m_done, CW'(m_scnt), m_err};
    endtask

    always @(posedge clk) model_step();

    // ---------------- observation ----------------
    logic [OW-1:0] obs;
    assign obs = {busy, s_ready, x_valid, x_in, y_in, frame_done, sample_cnt, underrun_err};

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [DW-1:0] got[$];
    int            vcyc[$];
    int            done_cyc[$];
    int            done_cnts[$];

    task automatic tick(input logic v, input logic [DW-1:0] d, input logic l);
        s_valid = v; s_data = d; s_last = l;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (x_valid === 1'b1) begin got.push_back(x_in); vcyc.push_back(cyc); end
        if (frame_done === 1'b1) begin done_cyc.push_back(cyc); done_cnts.push_back(int'(sample_cnt)); end
    endtask

    task automatic clear_obs();
        got.delete(); vcyc.delete(); done_cyc.delete(); done_cnts.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, '0, 1'b0);
        rst = 1'b0;
        clear_obs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [OW-1:0] rst_val;
        rst_val = {1'b0, 1'b1, 1'b0, {DW{1'b0}}, {DW{1'b0}}, 1'b0, {CW{1'b0}}, 1'b0};
        rst = 1'b1;
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        n_checks++;
        if (obs !== rst_val) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, rst_val); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== rst_val) begin n_fail++; $display("FAIL reset_idle cyc %0d: got %h want %h", cyc, obs, rst_val); end
        end
        clear_obs();
    endtask

    task automatic test_single_frame();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, DW'(i), i == 5);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL single_frame cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL single_frame cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (got.size() != 5 || done_cyc.size() != 1) begin
            n_fail++; $display("FAIL single_frame_counts: samples %0d frames %0d want 5 and 1", got.size(), done_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL single_frame_data[%0d]: got %0d want %0d", i, got[i], i + 1); end
            end
            n_checks++;
            if (vcyc[4] - vcyc[0] != 4) begin n_fail++; $display("FAIL single_frame_gapless: span %0d want 4", vcyc[4] - vcyc[0]); end
            n_checks++;
            if (done_cyc[0] - vcyc[4] != FL + 1) begin n_fail++; $display("FAIL single_frame_flush: gap %0d want %0d", done_cyc[0] - vcyc[4], FL + 1); end
            n_checks++;
            if (done_cnts[0] != 5) begin n_fail++; $display("FAIL single_frame_cnt: got %0d want 5", done_cnts[0]); end
        end
        n_checks++;
        if (busy !== 1'b0 || underrun_err !== 1'b0) begin n_fail++; $display("FAIL single_frame_end: busy %b err %b want 0 0", busy, underrun_err); end
    endtask

    task automatic test_backpressure();
        int  nxt;
        bit  acc;
        bit  saw_block;
        bit  saw_refill;
        do_reset();
        nxt = 1; saw_block = 0; saw_refill = 0;
        for (int c = 0; c < 60 && nxt <= 11; c++) begin
            acc = s_ready;
            tick(1'b1, DW'(nxt), nxt == 11);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL backpressure cyc %0d: got %h want %h", cyc, obs, m_exp); end
            if (acc) begin
                nxt++;
                if (nxt == 9 && !saw_block) begin
                    saw_block = 1;
                    n_checks++;
                    if (s_ready !== 1'b0) begin n_fail++; $display("FAIL backpressure_full: s_ready %b want 0", s_ready); end
                end
            end else if (saw_block && !saw_refill) begin
                saw_refill = 1;
                n_checks++;
                if (s_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_refill: s_ready %b want 1", s_ready); end
            end
        end
        n_checks++;
        if (nxt <= 11) begin n_fail++; $display("FAIL backpressure_timeout: accepted %0d want 11", nxt - 1); end
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL backpressure cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (got.size() != 11) begin n_fail++; $display("FAIL backpressure_len: got %0d want 11", got.size()); end
        else for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL backpressure_data[%0d]: got %0d want %0d", i, got[i], i + 1); end
        end
        n_checks++;
        if (done_cnts.size() != 1 || underrun_err !== 1'b0) begin
            n_fail++; $display("FAIL backpressure_end: frames %0d err %b want 1 0", done_cnts.size(), underrun_err);
        end else begin
            n_checks++;
            if (done_cnts[0] != 11) begin n_fail++; $display("FAIL backpressure_cnt: got %0d want 11", done_cnts[0]); end
        end
    endtask

    task automatic test_underrun();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, DW'(i), 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL underrun cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL underrun cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (underrun_err !== 1'b1 || x_valid !== 1'b0 || x_in !== '0) begin
            n_fail++; $display("FAIL underrun_flag: err %b valid %b x %0d want 1 0 0", underrun_err, x_valid, x_in);
        end
        tick(1'b1, DW'(9), 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL underrun cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (got.size() != 9) begin n_fail++; $display("FAIL underrun_len: got %0d want 9", got.size()); end
        else for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL underrun_data[%0d]: got %0d want %0d", i, got[i], i + 1); end
        end
        n_checks++;
        if (done_cnts.size() != 1) begin n_fail++; $display("FAIL underrun_frames: got %0d want 1", done_cnts.size()); end
        else begin
            n_checks++;
            if (done_cnts[0] != 9) begin n_fail++; $display("FAIL underrun_cnt: got %0d want 9", done_cnts[0]); end
        end
        n_checks++;
        if (underrun_err !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky: got %b want 1", underrun_err); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(1'b1, DW'(1), 1'b0);
        tick(1'b1, DW'(2), 1'b1);
        tick(1'b1, DW'(3), 1'b1);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL back_to_back cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (got.size() != 3 || done_cnts.size() != 2) begin
            n_fail++; $display("FAIL back_to_back_counts: samples %0d frames %0d want 3 and 2", got.size(), done_cnts.size());
        end else begin
            n_checks++;
            if (got[0] !== DW'(1) || got[1] !== DW'(2) || got[2] !== DW'(3)) begin
                n_fail++; $display("FAIL back_to_back_data: got %0d %0d %0d want 1 2 3", got[0], got[1], got[2]);
            end
            n_checks++;
            if (done_cyc[0] - vcyc[1] != FL + 1) begin n_fail++; $display("FAIL back_to_back_done_pos: gap %0d want %0d", done_cyc[0] - vcyc[1], FL + 1); end
            n_checks++;
            if (vcyc[2] - done_cyc[0] != 1) begin n_fail++; $display("FAIL back_to_back_restart: gap %0d want 1", vcyc[2] - done_cyc[0]); end
            n_checks++;
            if (done_cnts[0] != 2 || done_cnts[1] != 1) begin
                n_fail++; $display("FAIL back_to_back_cnt: got %0d %0d want 2 1", done_cnts[0], done_cnts[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        for (int i = 1; i <= 5; i++) tick(1'b1, DW'(i), i == 5);
        w = 0;
        while (got.size() < 5 && w < 20) begin tick(1'b0, '0, 1'b0); w++; end
        n_checks++;
        if (got.size() < 5) begin n_fail++; $display("FAIL reset_mid_timeout: got %0d samples want 5", got.size()); end
        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_mid_flush: busy %b want 1", busy); end
        rst = 1'b1;
        tick(1'b0, '0, 1'b0);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || x_in !== '0 || x_valid !== 1'b0 || s_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_state: busy %b x %0d valid %b ready %b done %b want 0 0 0 1 0",
                               busy, x_in, x_valid, s_ready, frame_done);
        end
        clear_obs();
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL reset_mid cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (done_cyc.size() != 0 || got.size() != 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: frames %0d samples %0d want 0 0", done_cyc.size(), got.size());
        end
        tick(1'b1, DW'(7), 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL reset_mid cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (got.size() != 1 || done_cnts.size() != 1) begin
            n_fail++; $display("FAIL reset_mid_after: samples %0d frames %0d want 1 1", got.size(), done_cnts.size());
        end else begin
            n_checks++;
            if (got[0] !== DW'(7) || done_cnts[0] != 1) begin
                n_fail++; $display("FAIL reset_mid_after_data: x %0d cnt %0d want 7 1", got[0], done_cnts[0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 1; i <= 8; i++) tick(1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, '0, 1'b0);
        for (int i = 9; i <= 21; i++) begin
            tick(1'b1, DW'(i), i == 21);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL simultaneous cyc %0d: got %h want %h", cyc, obs, m_exp); end
            n_checks++;
            if (s_ready !== 1'b1) begin n_fail++; $display("FAIL simultaneous_ready cyc %0d: got %b want 1", cyc, s_ready); end
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL simultaneous cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (got.size() != 21) begin n_fail++; $display("FAIL simultaneous_len: got %0d want 21", got.size()); end
        else for (int i = 0; i < 21; i++) begin
            n_checks++;
            if (got[i] !== DW'(i + 1)) begin n_fail++; $display("FAIL simultaneous_data[%0d]: got %0d want %0d", i, got[i], i + 1); end
        end
        n_checks++;
        if (underrun_err !== 1'b0 || done_cnts.size() != 1) begin
            n_fail++; $display("FAIL simultaneous_end: err %b frames %0d want 0 1", underrun_err, done_cnts.size());
        end else begin
            n_checks++;
            if (done_cnts[0] != 21) begin n_fail++; $display("FAIL simultaneous_cnt: got %0d want 21", done_cnts[0]); end
        end
    endtask

    task automatic test_random();
        bit acc;
        bit closed;
        do_reset();
        for (int c = 0; c < 900; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            tick($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 5) == 0);
            rst = 1'b0;
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL random cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        closed = 0;
        for (int c = 0; c < 40 && !closed; c++) begin
            acc = s_ready;
            tick(1'b1, DW'($urandom), 1'b1);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL random_close cyc %0d: got %h want %h", cyc, obs, m_exp); end
            if (acc) closed = 1;
        end
        n_checks++;
        if (!closed) begin n_fail++; $display("FAIL random_close_timeout: s_ready %b want 1", s_ready); end
        for (int c = 0; c < 120; c++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if (obs !== m_exp) begin n_fail++; $display("FAIL random_drain cyc %0d: got %h want %h", cyc, obs, m_exp); end
        end
        n_checks++;
        if (busy !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL random_drained: busy %b ready %b want 0 1", busy, s_ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_backpressure();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/b1_input_sequencer.md
Name: b1_input_sequencer

Overview:
Upstream feeder for the B1 convolution systolic array. It accepts a stream of input samples over a valid/ready handshake and buffers them in a FIFO. It then drives the array's x_in with one sample per clock and no gaps, holds y_in at zero, and appends a zero-flush tail after each frame so the array drains. It reports frame completion and a sample count, and raises a sticky error if the FIFO runs dry mid-frame.

Parameters:
DATA_W, 32, width of samples and of x_in/y_in
FIFO_DEPTH, 8, sample FIFO entries (power of 2, >=2)
FLUSH_LEN, 7, number of zero cycles driven after the last sample of a frame
CNT_W, 16, width of the per-frame sample counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_data  in  DATA_W  input sample
s_valid  in  1  s_data valid
s_last  in  1  marks final sample of a frame; qualified by s_valid
s_ready  out  1  FIFO can accept; equals !full
x_in  out  DATA_W  sample to array x_in; registered
y_in  out  DATA_W  partial-sum seed to array; constant 0
x_valid  out  1  x_in carries a real sample this cycle; registered
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the flush completes
sample_cnt  out  CNT_W  samples streamed in the finished frame; valid when frame_done=1, held until next frame_done
underrun_err  out  1  sticky; set on FIFO empty during STREAM before last

Behaviour:
- Reset (sync, rst=1 at an edge): FIFO emptied, frame counter cleared, state=IDLE. Outputs after reset: x_in=0, x_valid=0, frame_done=0, sample_cnt=0, underrun_err=0, busy=0, s_ready=1. rst overrides all other activity, including mid-stream.
- FIFO: stores {last, data}.
  - Push on s_valid && s_ready.
  - s_ready=!full. No push when full, even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- frames_q counter: +1 on push with last=1, -1 on pop with last=1; both in the same cycle leaves it unchanged.
- Start condition: frames_q>0 OR FIFO full.
- IDLE:
  - x_in=0, x_valid=0.
  - If the start condition holds at an edge: pop the head, register x_in=data and x_valid=1, set sample_cnt counter to 1, go to STREAM, or to FLUSH if the popped entry has last=1.
  - Latency: a sample accepted at edge E0 with last=1 into an empty idle FIFO appears on x_in after edge E1.
- STREAM:
  - Each edge, if FIFO non-empty: pop, drive x_in=data and x_valid=1, increment the count (saturating at all-ones).
  - If the popped entry has last=1, go to FLUSH.
  - If the FIFO is empty: set underrun_err=1, drive x_in=0 and x_valid=0, stay in STREAM (the array has no stall, so the frame is corrupted but sequencing continues).
- FLUSH:
  - Drive x_in=0, x_valid=0 for exactly FLUSH_LEN cycles, counted by flush_cnt.
  - On the final flush cycle edge: pulse frame_done=1 for one cycle, load sample_cnt with the count, go to IDLE.
- Back-to-back frames: at least one IDLE cycle between frames. frame_done coincides with that IDLE cycle; the next frame's first x_in appears the cycle after.
- y_in tied to 0 at all times.
- underrun_err clears only on rst.

Test Plan:
- Single frame: push 1,2,3,4,5 (last on 5) on consecutive cycles -> x_in = 1,2,3,4,5 on consecutive cycles with x_valid=1, then 7 cycles x_in=0 and x_valid=0, then frame_done=1 for 1 cycle with sample_cnt=5, busy=0, underrun_err=0.
- Back-pressure: push 10 samples without last while streaming is not yet started -> after 8 accepted, s_ready=0. Streaming starts (FIFO full), s_ready returns to 1 after the first pop. Remaining 2 samples are accepted and streamed in order 1..10.
- Underrun: fill FIFO with 8 samples (no last), stop s_valid -> x_in = 1..8, next cycle x_valid=0, x_in=0, underrun_err=1 and stays 1. Then push 9 with last -> 9 streamed, flush, frame_done with sample_cnt=9.
- Back-to-back: frame A = {1,2} last, frame B = {3} last, pushed contiguously -> 1,2, 7 zeros, frame_done(cnt=2) during the IDLE cycle, then 3, 7 zeros, frame_done(cnt=1).
- Reset mid-operation: assert rst for 1 cycle during FLUSH of a 5-sample frame -> next cycle busy=0, x_in=0, frame_done never pulses, s_ready=1, FIFO empty. A subsequent frame {7} last streams normally.
- Simultaneous push/pop: streaming while pushing one sample per cycle with the FIFO at count 3 -> count stays 3, no sample dropped or duplicated on x_in.
